// File: rtl/fetch_queue.sv
// Instruction fetch queue: credit-limited fetch requests, in-order response capture,
// and a head-presented decode buffer with redirect flush and stale-response dropping.
module fetch_queue #(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  input  logic        stall_D,
  output logic        valid_D,
  output logic [31:0] instr_D,
  output logic [31:0] pc_D,
  output logic [31:0] pcplus4_D
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = AW + 1;
  localparam logic [AW-1:0] A_ONE = AW'(1);
  localparam logic [CW-1:0] C_ONE = CW'(1);

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
  } fq_entry_t;

  logic [31:0]   r_pc;
  logic [CW-1:0] r_out;
  logic [CW-1:0] r_drop;
  logic [CW-1:0] r_cnt;
  logic [AW-1:0] r_wp, r_rp;
  logic [AW-1:0] r_awp, r_arp;
  fq_entry_t     r_buf   [DEPTH];
  logic [31:0]   r_afifo [DEPTH];

  logic [CW:0]   w_sum;
  logic          w_credit;
  logic          w_gnt;
  logic          w_rv;
  logic          w_rv_drop;
  logic          w_enq;
  logic          w_deq;
  logic [31:0]   w_rpc;

  // Buffered plus in-flight (including to-be-dropped) must leave a slot per response.
  assign w_sum     = {1'b0, r_cnt} + {1'b0, r_out};
  assign w_credit  = w_sum < (CW+1)'(DEPTH);
  assign imem_req  = reset & ~redirect & w_credit;
  assign imem_addr = r_pc;

  assign w_gnt     = imem_req & imem_gnt;
  assign w_rv      = imem_rvalid & (r_out != '0);
  assign w_rv_drop = w_rv & (r_drop != '0);
  assign w_enq     = w_rv & (r_drop == '0) & ~redirect;
  assign w_deq     = valid_D & ~stall_D & ~redirect;
  assign w_rpc     = redirect_pc & 32'hFFFF_FFFC;

  assign valid_D   = (r_cnt != '0);
  assign instr_D   = valid_D ? r_buf[r_rp].instr       : '0;
  assign pc_D      = valid_D ? r_buf[r_rp].pc          : '0;
  assign pcplus4_D = valid_D ? r_buf[r_rp].pc + 32'd4  : '0;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_pc   <= RESET_PC;
      r_out  <= '0;
      r_drop <= '0;
      r_cnt  <= '0;
      r_wp   <= '0;
      r_rp   <= '0;
      r_awp  <= '0;
      r_arp  <= '0;
    end else begin
      if (redirect)   r_pc <= w_rpc;
      else if (w_gnt) r_pc <= r_pc + 32'd4;

      r_out <= r_out + (w_gnt ? C_ONE : '0) - (w_rv ? C_ONE : '0);
      if (w_gnt) r_awp <= r_awp + A_ONE;
      if (w_rv)  r_arp <= r_arp + A_ONE;

      // Address FIFO keeps running across a redirect; stale responses still pop it.
      if (redirect) begin
        r_drop <= r_out - (w_rv ? C_ONE : '0);
        r_cnt  <= '0;
        r_wp   <= '0;
        r_rp   <= '0;
      end else begin
        if (w_rv_drop) r_drop <= r_drop - C_ONE;
        if (w_enq)     r_wp   <= r_wp + A_ONE;
        if (w_deq)     r_rp   <= r_rp + A_ONE;
        r_cnt <= r_cnt + (w_enq ? C_ONE : '0) - (w_deq ? C_ONE : '0);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_gnt) r_afifo[r_awp] <= r_pc;
    if (w_enq) r_buf[r_wp]    <= '{instr: imem_rdata, pc: r_afifo[r_arp]};
  end

endmodule

// File: doc/fetch_queue.md
FETCH_QUEUE -- requirements
Module: fetch_queue

Interface
REQ-001 SHALL have parameter DEPTH, default 4, number of instruction buffer entries (power of two, 2..16).
REQ-002 SHALL have parameter RESET_PC, default 32'h0000_0000, first fetch address after reset.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on posedge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-low reset (asserted when 0).
REQ-005 SHALL have port imem_req  output  1  fetch request valid.
REQ-006 SHALL have port imem_addr  output  32  fetch word address, byte-addressed, bits[1:0]=0.
REQ-007 SHALL have port imem_gnt  input  1  request accepted when imem_req&&imem_gnt.
REQ-008 SHALL have port imem_rvalid  input  1  response data valid; in order; >=1 cycle after its grant.
REQ-009 SHALL have port imem_rdata  input  32  instruction word.
REQ-010 SHALL have port redirect  input  1  branch/jump taken; flush and refetch.
REQ-011 SHALL have port redirect_pc  input  32  target address; bits[1:0] ignored (forced 0).
REQ-012 SHALL have port stall_D  input  1  decode pipeline register cannot accept this cycle.
REQ-013 SHALL have port valid_D  output  1  instr_D/pc_D/pcplus4_D hold a valid instruction.
REQ-014 SHALL have port instr_D  output  32  instruction at queue head.
REQ-015 SHALL have port pc_D  output  32  address of instr_D.
REQ-016 SHALL have port pcplus4_D  output  32  pc_D+4, modulo 2^32.

Function
REQ-017 SHALL keep fetch PC register; on grant, PC <= PC+4 (wraps 32'hFFFF_FFFC -> 0).
REQ-018 SHALL drive imem_addr = fetch PC; imem_req = 1 only when occupancy + outstanding < DEPTH and redirect = 0.
REQ-019 SHALL hold imem_addr stable while imem_req=1 and imem_gnt=0.
REQ-020 SHALL track outstanding (granted, response pending) count, 0..DEPTH; +1 on grant, -1 on rvalid, both same cycle = unchanged.
REQ-021 SHALL write {imem_rdata, address} into buffer tail on accepted imem_rvalid; address from an in-order address FIFO or tag equivalent.
REQ-022 SHALL never overflow: credit rule in REQ-018 guarantees a slot for every outstanding response.
REQ-023 SHALL present head entry combinationally: valid_D = buffer non-empty; instr_D/pc_D/pcplus4_D = 0 when empty.
REQ-024 SHALL dequeue head when valid_D=1 and stall_D=0; enqueue and dequeue same cycle keep occupancy unchanged.
REQ-025 SHALL, on empty buffer with rvalid same cycle, show data at valid_D next cycle (one-cycle response-to-decode latency; no bypass).
REQ-026 SHALL, on redirect=1: next cycle buffer empty, fetch PC = redirect_pc, drop counter = outstanding minus any rvalid that cycle, no dequeue; stall_D ignored.
REQ-027 SHALL discard (not enqueue) the next drop-counter responses after redirect, decrementing per rvalid; issue of new requests continues under REQ-018 counting dropped ones as outstanding.
REQ-028 SHALL ignore grant in the redirect cycle (imem_req=0 then), so no request to the stale PC is accepted.
REQ-029 SHALL apply back-to-back redirects by latest target; drop counter accumulates all unretired outstanding.
REQ-030 SHALL treat imem_rvalid with outstanding=0 as protocol error: ignored, state unchanged.

Reset
REQ-031 SHALL on reset=0 immediately: fetch PC=RESET_PC, buffer empty, outstanding=0, drop=0, imem_req=0, valid_D=0, instr_D/pc_D/pcplus4_D=0.
REQ-032 SHALL after reset release, assert imem_req=1 with imem_addr=RESET_PC on the first clock edge-aligned cycle.
REQ-033 SHALL on reset mid-operation drop all buffered and in-flight instructions; later stray rvalid handled per REQ-030.

Verification
REQ-034 Reset, gnt=1, rvalid one cycle after each grant, stall_D=0 -> valid_D stream pc_D 0,4,8,12 one per cycle after 2-cycle fill.
REQ-035 stall_D=1 continuously, zero-latency-ish memory -> exactly DEPTH(4) grants, imem_req drops to 0, buffer holds pc 0..12; release stall -> drained in order.
REQ-036 Redirect to 32'h100 with 2 outstanding -> next 2 rvalid discarded, first valid_D shows pc_D=32'h100, pcplus4_D=32'h104.
REQ-037 imem_gnt=0 for 5 cycles -> imem_req=1 and imem_addr constant throughout.
REQ-038 redirect_pc=32'hFFFF_FFFE -> fetch 32'hFFFF_FFFC, then 0; pcplus4_D of first = 0.
REQ-039 reset=0 asserted with 3 buffered entries -> valid_D=0 same cycle; after release, first fetch RESET_PC.
